// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and encodings for the ALU control unit
//
// Purpose: FSM state type, opcode constants and instruction field positions
//          used by the control unit decode.
// Ports:   none (package).
package cu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      EXECUTE = 2'd2,
      HALT    = 2'd3
   } cu_state_t;

   // Opcode prefixes. ALU ops are identified by IR[7]=0.
   localparam logic [1:0] OP_LDI  = 2'b10;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_JZ   = 4'b1101;
   localparam logic [3:0] OP_JN   = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   // Instruction field positions (LSB of each field).
   localparam int RD_LSB     = 0;   // ALU destination / operand A
   localparam int RB_LSB     = 2;   // ALU operand B
   localparam int LDI_RD_LSB = 4;   // LDI destination
   localparam int IMM_LSB    = 0;   // LDI / jump immediate

   function automatic logic is_alu_op(input logic [7:0] ir);
      return ~ir[7];
   endfunction

endpackage

// File: rtl/regfile4x4.sv
// rtl/regfile4x4.sv - 4x4-bit register file, one write port, three read ports
//
// Purpose: general-purpose register storage for the control unit.
// Ports:   clk, rst      - clock, synchronous active-high reset (clears all)
//          we, waddr, wdata - synchronous write port
//          raddr_a/rdata_a, raddr_b/rdata_b, raddr_d/rdata_d
//                        - combinational read ports (operand A, B, debug)
module regfile4x4 (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [3:0] wdata,
   input  logic [1:0] raddr_a,
   input  logic [1:0] raddr_b,
   input  logic [1:0] raddr_d,
   output logic [3:0] rdata_a,
   output logic [3:0] rdata_b,
   output logic [3:0] rdata_d
);

   logic [3:0] regs [4];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs[i] <= 4'd0;
         end
      end else if (we) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a = regs[raddr_a];
   assign rdata_b = regs[raddr_b];
   assign rdata_d = regs[raddr_d];

endmodule

// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - fetch/execute controller driving a 4-bit ALU
//
// Purpose: fetches 8-bit instructions from a 16-entry ROM, decodes them into
//          ALU select/operands, writes results back to a 4x4 register file,
//          latches ALU flags and handles LDI, JMP, JZ, JN and HALT.
// Ports:   clk, rst                 - clock, synchronous active-high reset
//          run                      - start/restart (IDLE and HALT only)
//          imem_addr, imem_data     - instruction ROM address / read data
//          alu_s0, alu_s1, alu_cin  - ALU operation select
//          alu_a, alu_b             - ALU operands R[IR[1:0]], R[IR[3:2]]
//          alu_g, alu_cout, alu_z, alu_n - ALU result and flags
//          dbg_sel, dbg_reg         - debug register read
//          flags                    - latched {C,Z,N}
//          busy, halted             - status decoded from state
module alu_control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   output logic [3:0] imem_addr,
   input  logic [7:0] imem_data,
   output logic       alu_s0,
   output logic       alu_s1,
   output logic       alu_cin,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   input  logic [3:0] alu_g,
   input  logic       alu_cout,
   input  logic       alu_z,
   input  logic       alu_n,
   input  logic [1:0] dbg_sel,
   output logic [3:0] dbg_reg,
   output logic [2:0] flags,
   output logic       busy,
   output logic       halted
);

   cu_state_t  state;
   logic [3:0] pc;
   logic [7:0] ir;

   logic       exec_alu;
   logic       exec_ldi;
   logic       rf_we;
   logic [1:0] rf_waddr;
   logic [3:0] rf_wdata;
   logic [3:0] imm;

   assign imm      = ir[IMM_LSB +: 4];
   assign exec_alu = (state == EXECUTE) && is_alu_op(ir);
   assign exec_ldi = (state == EXECUTE) && (ir[7:6] == OP_LDI);

   // Only ALU ops and LDI write the register file; LDI takes its
   // destination from IR[5:4] instead of IR[1:0].
   assign rf_we    = exec_alu || exec_ldi;
   assign rf_waddr = exec_ldi ? ir[LDI_RD_LSB +: 2] : ir[RD_LSB +: 2];
   assign rf_wdata = exec_ldi ? imm : alu_g;

   regfile4x4 u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (ir[RD_LSB +: 2]),
      .raddr_b (ir[RB_LSB +: 2]),
      .raddr_d (dbg_sel),
      .rdata_a (alu_a),
      .rdata_b (alu_b),
      .rdata_d (dbg_reg)
   );

   // Select lines are forced low outside an ALU execute so the ALU sees a
   // quiet pass-through while fetching or running non-ALU instructions.
   assign alu_s1  = exec_alu & ir[6];
   assign alu_s0  = exec_alu & ir[5];
   assign alu_cin = exec_alu & ir[4];

   assign imem_addr = pc;
   assign busy      = (state == FETCH) || (state == EXECUTE);
   assign halted    = (state == HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pc    <= 4'd0;
         ir    <= 8'd0;
         flags <= 3'd0;
      end else begin
         case (state)
            IDLE: begin
               if (run) begin
                  state <= FETCH;
               end
            end
            FETCH: begin
               ir    <= imem_data;
               pc    <= pc + 4'd1;
               state <= EXECUTE;
            end
            EXECUTE: begin
               state <= FETCH;
               if (exec_alu) begin
                  flags <= {alu_cout, alu_z, alu_n};
               end
               // Conditional jumps test the flags latched by earlier ALU ops.
               case (ir[7:4])
                  OP_JMP:  pc <= imm;
                  OP_JZ:   if (flags[1]) pc <= imm;
                  OP_JN:   if (flags[0]) pc <= imm;
                  OP_HALT: state <= HALT;
                  default: ;
               endcase
            end
            HALT: begin
               // Restart from address 0; registers and flags carry over.
               if (run) begin
                  state <= FETCH;
                  pc    <= 4'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - self-checking bench for alu_control_unit
`timescale 1ns/1ps
module tb_alu_control_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] imem_addr;
   logic [7:0] imem_data;
   logic       alu_s0, alu_s1, alu_cin;
   logic [3:0] alu_a, alu_b, alu_g;
   logic       alu_cout, alu_z, alu_n;
   logic [1:0] dbg_sel = 2'd0;
   logic [3:0] dbg_reg;
   logic [2:0] flags;
   logic       busy, halted;

   logic [7:0] rom [16];
   logic [4:0] alu_sum;

   int errors = 0;
   int checks = 0;

   always #10 clk = ~clk;

   assign imem_data = rom[imem_addr];

   // Arithmetic ALU: 00 A+cin, 01 A+B+cin, 10 A+~B+cin, 11 A+1111+cin
   always_comb begin
      alu_sum = 5'd0;
      case ({alu_s1, alu_s0})
         2'b00: alu_sum = {1'b0, alu_a} + {4'd0, alu_cin};
         2'b01: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
         2'b10: alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
         2'b11: alu_sum = {1'b0, alu_a} + 5'h0F + {4'd0, alu_cin};
         default: alu_sum = 5'd0;
      endcase
   end
   assign alu_g    = alu_sum[3:0];
   assign alu_cout = alu_sum[4];
   assign alu_z    = (alu_sum[3:0] == 4'd0);
   assign alu_n    = alu_sum[3];

   alu_control_unit dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .alu_s0    (alu_s0),
      .alu_s1    (alu_s1),
      .alu_cin   (alu_cin),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_g     (alu_g),
      .alu_cout  (alu_cout),
      .alu_z     (alu_z),
      .alu_n     (alu_n),
      .dbg_sel   (dbg_sel),
      .dbg_reg   (dbg_reg),
      .flags     (flags),
      .busy      (busy),
      .halted    (halted)
   );

   task automatic fill_rom(input logic [7:0] v);
      for (int i = 0; i < 16; i++) rom[i] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      run = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic start_run();
      run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] idx, output logic [3:0] v);
      dbg_sel = idx;
      #1;
      v = dbg_reg;
   endtask

   task automatic test_reset();
      logic [3:0] r;
      rst = 1'b1;
      run = 1'b0;
      fill_rom(8'hF0);
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
      checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL reset_imem_addr: got %0h expected 0", imem_addr); end
      checks++; if ({alu_s1, alu_s0, alu_cin} !== 3'b000) begin errors++; $display("FAIL reset_alu_sel: got %03b expected 000", {alu_s1, alu_s0, alu_cin}); end
      checks++; if ({alu_a, alu_b} !== 8'h00) begin errors++; $display("FAIL reset_alu_ab: got %02h expected 00", {alu_a, alu_b}); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %03b expected 000", flags); end
      for (int i = 0; i < 4; i++) begin
         read_reg(i[1:0], r);
         checks++; if (r !== 4'd0) begin errors++; $display("FAIL reset_reg%0d: got %0h expected 0", i, r); end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_run: busy got %0b expected 0", busy); end
   endtask

   task automatic test_add_program();
      logic [3:0] r;
      int cyc;
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'h85; rom[1] = 8'h93; rom[2] = 8'h24; rom[3] = 8'hF0;
      start_run();
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL add_busy_fetch: got %0b expected 1", busy); end
      cyc = 0;
      while (halted !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) begin
            read_reg(2'd0, r);
            checks++; if (r !== 4'd5) begin errors++; $display("FAIL add_first_writeback: R0 got %0h expected 5", r); end
         end
         if (cyc == 5) begin
            checks++; if ({alu_s1, alu_s0, alu_cin} !== 3'b010) begin errors++; $display("FAIL add_sel: got %03b expected 010", {alu_s1, alu_s0, alu_cin}); end
            checks++; if ({alu_a, alu_b} !== 8'h53) begin errors++; $display("FAIL add_operands: got %02h expected 53", {alu_a, alu_b}); end
         end
         if (cyc == 6) begin
            checks++; if ({alu_s1, alu_s0, alu_cin} !== 3'b000) begin errors++; $display("FAIL add_sel_in_fetch: got %03b expected 000", {alu_s1, alu_s0, alu_cin}); end
         end
      end
      checks++; if (cyc != 8) begin errors++; $display("FAIL add_halt_latency: got %0d cycles expected 8", cyc); end
      read_reg(2'd0, r);
      checks++; if (r !== 4'd8) begin errors++; $display("FAIL add_r0: got %0h expected 8", r); end
      read_reg(2'd1, r);
      checks++; if (r !== 4'd3) begin errors++; $display("FAIL add_r1: got %0h expected 3", r); end
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL add_flags: got %03b expected 001 (C=0)", flags); end
      checks++; if (imem_addr !== 4'd4) begin errors++; $display("FAIL add_pc_at_halt: got %0h expected 4", imem_addr); end
   endtask

   task automatic test_sub_jn();
      logic [3:0] r;
      logic [3:0] fetch_addr;
      int cyc;
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'h83; rom[1] = 8'h95; rom[2] = 8'h54; rom[3] = 8'hEA;
      rom[4] = 8'h8F; rom[10] = 8'hF0;
      start_run();
      cyc = 0;
      fetch_addr = 4'hX;
      while (halted !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 8) fetch_addr = imem_addr;
      end
      checks++; if (cyc != 10) begin errors++; $display("FAIL jn_halt_latency: got %0d cycles expected 10", cyc); end
      checks++; if (fetch_addr !== 4'd10) begin errors++; $display("FAIL jn_target_fetch: got %0h expected a", fetch_addr); end
      read_reg(2'd0, r);
      checks++; if (r !== 4'hE) begin errors++; $display("FAIL sub_r0: got %0h expected e", r); end
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL sub_flags: got %03b expected 001", flags); end
      checks++; if (imem_addr !== 4'd11) begin errors++; $display("FAIL jn_pc_at_halt: got %0h expected b", imem_addr); end
   endtask

   task automatic test_jz();
      logic [3:0] r;
      int cyc;
      // Not taken: Z=0 straight out of reset.
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'hD7; rom[7] = 8'h8F;
      start_run();
      cyc = 0;
      while (halted !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 2) begin
            checks++; if (imem_addr !== 4'd1) begin errors++; $display("FAIL jz_not_taken_fetch: got %0h expected 1", imem_addr); end
         end
      end
      checks++; if (cyc != 4) begin errors++; $display("FAIL jz_not_taken_latency: got %0d cycles expected 4", cyc); end
      read_reg(2'd0, r);
      checks++; if (r !== 4'd0) begin errors++; $display("FAIL jz_not_taken_r0: got %0h expected 0", r); end
      // Taken: SUB R0,R0 sets C=1,Z=1.
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'h50; rom[1] = 8'hD7; rom[2] = 8'h8F;
      start_run();
      cyc = 0;
      while (halted !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 4) begin
            checks++; if (imem_addr !== 4'd7) begin errors++; $display("FAIL jz_taken_fetch: got %0h expected 7", imem_addr); end
         end
      end
      checks++; if (cyc != 6) begin errors++; $display("FAIL jz_taken_latency: got %0d cycles expected 6", cyc); end
      checks++; if (flags !== 3'b110) begin errors++; $display("FAIL jz_taken_flags: got %03b expected 110", flags); end
   endtask

   task automatic test_pc_wrap();
      logic [3:0] r;
      for (int pass = 0; pass < 2; pass++) begin
         do_reset();
         rom[0] = 8'h12;
         for (int i = 1; i < 15; i++) rom[i] = 8'h80 | i[7:0];
         rom[15] = (pass == 0) ? 8'hB9 : 8'hC0;
         start_run();
         for (int c = 1; c <= 34; c++) begin
            @(posedge clk); #1;
            if (c == 30) begin
               checks++; if (imem_addr !== 4'd15) begin errors++; $display("FAIL wrap%0d_fetch15: got %0h expected f", pass, imem_addr); end
            end
            if (c == 31) begin
               checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL wrap%0d_increment: got %0h expected 0", pass, imem_addr); end
            end
            if (c == 32) begin
               checks++; if (imem_addr !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL wrap%0d_refetch0: addr %0h busy %0b expected 0 1", pass, imem_addr, busy); end
            end
         end
         read_reg(2'd2, r);
         checks++; if (r !== 4'd2) begin errors++; $display("FAIL wrap%0d_r2: got %0h expected 2", pass, r); end
         read_reg(2'd3, r);
         checks++; if (r !== ((pass == 0) ? 4'd9 : 4'd0)) begin errors++; $display("FAIL wrap%0d_r3: got %0h expected %0h", pass, r, (pass == 0) ? 4'd9 : 4'd0); end
      end
   endtask

   task automatic test_reset_mid_exec();
      logic [3:0] r;
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'h97; rom[1] = 8'h12;
      start_run();
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
      end
      checks++; if ({alu_s1, alu_s0, alu_cin} !== 3'b001) begin errors++; $display("FAIL inc_sel: got %03b expected 001", {alu_s1, alu_s0, alu_cin}); end
      read_reg(2'd1, r);
      checks++; if (r !== 4'd7) begin errors++; $display("FAIL pre_reset_r1: got %0h expected 7", r); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      read_reg(2'd2, r);
      checks++; if (r !== 4'd0) begin errors++; $display("FAIL abort_r2: got %0h expected 0", r); end
      read_reg(2'd1, r);
      checks++; if (r !== 4'd0) begin errors++; $display("FAIL abort_r1: got %0h expected 0", r); end
      checks++; if ({busy, halted} !== 2'b00) begin errors++; $display("FAIL abort_status: got %02b expected 00", {busy, halted}); end
      checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL abort_pc: got %0h expected 0", imem_addr); end
      checks++; if ({alu_s1, alu_s0, alu_cin, alu_a, alu_b, flags} !== 14'd0) begin errors++; $display("FAIL abort_alu_flags: got %014b expected 0", {alu_s1, alu_s0, alu_cin, alu_a, alu_b, flags}); end
      start_run();
      checks++; if (imem_addr !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL abort_restart: addr %0h busy %0b expected 0 1", imem_addr, busy); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      read_reg(2'd1, r);
      checks++; if (r !== 4'd7) begin errors++; $display("FAIL abort_rerun_r1: got %0h expected 7", r); end
   endtask

   task automatic test_halt_restart();
      logic [3:0] r;
      int cyc;
      do_reset();
      fill_rom(8'hF0);
      rom[0] = 8'h85; rom[1] = 8'h96; rom[2] = 8'h5A; rom[3] = 8'hF0;
      start_run();
      cyc = 0;
      while (halted !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++; if (cyc != 8) begin errors++; $display("FAIL halt_latency: got %0d cycles expected 8", cyc); end
      run = 1'b1;
      @(posedge clk); #1;
      checks++; if ({busy, halted} !== 2'b10) begin errors++; $display("FAIL restart_status: got %02b expected 10", {busy, halted}); end
      checks++; if (imem_addr !== 4'd0) begin errors++; $display("FAIL restart_pc: got %0h expected 0", imem_addr); end
      checks++; if (flags !== 3'b110) begin errors++; $display("FAIL restart_flags: got %03b expected 110", flags); end
      read_reg(2'd0, r);
      checks++; if (r !== 4'd5) begin errors++; $display("FAIL restart_r0: got %0h expected 5", r); end
      read_reg(2'd1, r);
      checks++; if (r !== 4'd6) begin errors++; $display("FAIL restart_r1: got %0h expected 6", r); end
      @(posedge clk); #1;
      checks++; if (imem_addr !== 4'd1) begin errors++; $display("FAIL run_ignored_exec: got %0h expected 1", imem_addr); end
      @(posedge clk); #1;
      checks++; if (imem_addr !== 4'd1 || busy !== 1'b1) begin errors++; $display("FAIL run_ignored_fetch: addr %0h busy %0b expected 1 1", imem_addr, busy); end
      run = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_program();
      test_sub_jn();
      test_jz();
      test_pc_wrap();
      test_reset_mid_exec();
      test_halt_restart();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
